// File: rtl/mult_seq_pkg.sv
// Shared definitions for the digit-serial multiplier controller.
//   state_e      : FSM encoding (IDLE, RUN, DONE), 2 bits
//   digit_cnt_w  : digit-counter width ceil(log2(WIDTH/2)), minimum 1
package mult_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int digit_cnt_w(input int width);
    int d;
    d = width / 2;
    return (d <= 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/mult_digit_2x2.sv
// Combinational 2-bit x 2-bit -> 4-bit unsigned multiplier.
//   a_i [1:0] : multiplicand digit
//   b_i [1:0] : multiplier digit
//   p_o [3:0] : product
// Built as shift-and-add of the two single-bit sub-products.
module mult_digit_2x2 (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);

  logic [3:0] sp0, sp1;

  assign sp0 = b_i[0] ? {2'b00, a_i} : 4'd0;
  assign sp1 = b_i[1] ? {1'b0, a_i, 1'b0} : 4'd0;
  assign p_o = sp0 + sp1;

endmodule

// File: rtl/multiplier_digit_serial_controller.sv
// Digit-serial WIDTH x WIDTH unsigned multiplier. One 2x2 digit product is
// accumulated per clock; a product takes (WIDTH/2)^2 RUN steps.
//   Clk_In, Reset_N_In    : clock, async active-low reset
//   Start_In              : request, accepted when Ready_Out = 1
//   Data_A_In, Data_B_In  : operands, sampled on the accept edge
//   Ready_Out             : controller idle
//   Done_Out              : one-cycle pulse, result valid from here on
//   Multiplied_Result_Out : registered product, held until next Done_Out
// Optional build macro: MULT_SEQ_ZERO_SKIP_EN -- a zero operand bypasses RUN
// and completes one cycle after accept.
module multiplier_digit_serial_controller
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               Clk_In,
  input  logic               Reset_N_In,
  input  logic               Start_In,
  input  logic [WIDTH-1:0]   Data_A_In,
  input  logic [WIDTH-1:0]   Data_B_In,
  output logic               Ready_Out,
  output logic               Done_Out,
  output logic [2*WIDTH-1:0] Multiplied_Result_Out
);

  localparam int D  = WIDTH / 2;
  localparam int CW = digit_cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] DMAX = CW'(D - 1);

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    i_q, i_d, j_q, j_d;
  logic [PW-1:0]    acc_q, acc_d, res_q, res_d;
  logic             done_q, done_d;

  logic [1:0]    a_dig, b_dig;
  logic [3:0]    pp;
  logic [CW+1:0] sh;
  logic [PW-1:0] pp_sh;

  assign a_dig = a_q[2*i_q +: 2];
  assign b_dig = b_q[2*j_q +: 2];

  mult_digit_2x2 u_mul (
    .a_i (a_dig),
    .b_i (b_dig),
    .p_o (pp)
  );

  // Shift amount 2*(i+j); CW+2 bits covers the maximum 4*(D-1).
  assign sh    = ({2'b00, i_q} + {2'b00, j_q}) << 1;
  assign pp_sh = {{(PW-4){1'b0}}, pp} << sh;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start_In) begin
          a_d     = Data_A_In;
          b_d     = Data_B_In;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = ST_RUN;
`ifdef MULT_SEQ_ZERO_SKIP_EN
          if (Data_A_In == '0 || Data_B_In == '0) begin
            state_d = ST_DONE;
            res_d   = '0;
            done_d  = 1'b1;
          end
`endif
        end
      end
      ST_RUN: begin
        acc_d = acc_q + pp_sh;
        if (j_q == DMAX) begin
          j_d = '0;
          if (i_q == DMAX) begin
            i_d     = '0;
            res_d   = acc_q + pp_sh;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign Ready_Out             = (state_q == ST_IDLE);
  assign Done_Out              = done_q;
  assign Multiplied_Result_Out = res_q;

endmodule

// File: tb/tb_multiplier_digit_serial_controller.sv
module tb_multiplier_digit_serial_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        ready, done;
  logic [15:0] result;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  multiplier_digit_serial_controller #(.WIDTH(8)) dut (
    .Clk_In                (clk),
    .Reset_N_In            (rst_n),
    .Start_In              (start),
    .Data_A_In             (a),
    .Data_B_In             (b),
    .Ready_Out             (ready),
    .Done_Out              (done),
    .Multiplied_Result_Out (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Latency counts the accept cycle as 1: Done visible right after the
  // accept edge gives 1, after S further edges gives S+1.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, "_ready_pre"}, ready, 1);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~av; b = ~bv;             // later operand changes must not matter
    wait_done(lat);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, result, exp);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_ready_after"}, ready, 1);
    chk({tag, "_result_held"}, result, exp);
  endtask

  initial begin
    int lat, n, seen;

    #3;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("ff_ff", 8'hFF, 8'hFF, 16'hFE01, 17);
    run_op("03_02", 8'h03, 8'h02, 16'h0006, 17);
    run_op("a5_3c", 8'hA5, 8'h3C, 16'h26AC, 17);

    // Start pulse during RUN is ignored.
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    chk("ign_ready_run", ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_ready_still0", ready, 0);
    lat = 6;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_latency", lat, 17);
    chk("ign_result", result, 16'h03A8);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("ign_single_done", seen, 0);

    // Reset mid-RUN discards the operation.
    @(negedge clk);
    a = 8'h55; b = 8'h66; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", ready, 1);
    chk("mrst_done", done, 0);
    chk("mrst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("mrst_no_done", seen, 0);
    run_op("07_09", 8'h07, 8'h09, 16'h003F, 17);

`ifdef MULT_SEQ_ZERO_SKIP_EN
    run_op("zero", 8'h00, 8'h55, 16'h0000, 1);
`else
    run_op("zero", 8'h00, 8'h55, 16'h0000, 17);
`endif

    // Start held high: back-to-back products every S+2 cycles.
    @(negedge clk);
    a = 8'h10; b = 8'h10; start = 1'b1;
    @(posedge clk); #1;
    wait_done(lat);
    chk("held_first_lat", lat, 17);
    chk("held_res0", result, 16'h0100);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!done && n < 60);
      chk($sformatf("held_spacing%0d", k), n, 18);
      chk($sformatf("held_res%0d", k + 1), result, 16'h0100);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("held_idle_end", ready, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
